// File: rtl/gen_win_kxk.sv
// gen_win_kxk: KxK sliding-window generator over a raster pixel stream with K-1 line buffers.
// Define GEN_WIN_COORD_EN to add win_row/win_col (top-left coordinate of each window).
module gen_win_kxk #(
   parameter int DATA_W = 9,
   parameter int K      = 5,
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int STRIDE = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       pix_valid,
   output logic                       pix_ready,
   input  logic [DATA_W-1:0]          pix_data,
   output logic                       win_valid,
   input  logic                       win_ready,
   output logic [K*K*DATA_W-1:0]      win_data,
   output logic                       win_last
`ifdef GEN_WIN_COORD_EN
   ,
   output logic [$clog2(IMG_H)-1:0]   win_row,
   output logic [$clog2(IMG_W)-1:0]   win_col
`endif
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int PW = STRIDE > 1 ? $clog2(STRIDE) : 1;

   logic [DATA_W-1:0]     lb_q  [K-1][IMG_W];
   logic [DATA_W-1:0]     win_q [K][K];
   logic [DATA_W-1:0]     win_d [K][K];
   logic [DATA_W-1:0]     colv  [K];
   logic [K*K*DATA_W-1:0] flat_d, data_q;
   logic [CW-1:0]         col_q, col_d;
   logic [RW-1:0]         row_q, row_d;
   logic [PW-1:0]         cph_q, cph_d, rph_q, rph_d;
   logic                  rdy_q, vld_q, last_q, acc, col_end, row_end, qual;
`ifdef GEN_WIN_COORD_EN
   logic [RW-1:0]         wrow_q;
   logic [CW-1:0]         wcol_q;
   assign win_row = wrow_q;
   assign win_col = wcol_q;
`endif

   assign pix_ready = rdy_q && (!vld_q || win_ready);
   assign acc       = pix_valid && pix_ready;
   assign win_valid = vld_q;
   assign win_data  = data_q;
   assign win_last  = last_q;

   assign col_end = col_q == CW'(IMG_W-1);
   assign row_end = row_q == RW'(IMG_H-1);
   assign qual    = col_q >= CW'(K-1) && row_q >= RW'(K-1) && cph_q == '0 && rph_q == '0;
   assign col_d   = col_end ? '0 : col_q + 1'b1;
   assign row_d   = !col_end ? row_q : row_end ? '0 : row_q + 1'b1;
   // Stride phases stay at 0 until the first full window position, then count modulo STRIDE.
   assign cph_d   = (col_end || col_q < CW'(K-1) || cph_q == PW'(STRIDE-1)) ? '0 : cph_q + 1'b1;
   assign rph_d   = !col_end ? rph_q :
                    (row_end || row_q < RW'(K-1) || rph_q == PW'(STRIDE-1)) ? '0 : rph_q + 1'b1;

   always_comb begin
      for (int r = 0; r < K-1; r++) colv[r] = lb_q[r][col_q];
      colv[K-1] = pix_data;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K-1; c++) win_d[r][c] = win_q[r][c+1];
         win_d[r][K-1] = colv[r];
      end
      flat_d = '0;
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++) flat_d[(r*K+c)*DATA_W +: DATA_W] = win_d[r][c];
   end

   // Line buffers and window shift register hold data only; row/column gating masks stale contents.
   always_ff @(posedge clk)
      if (acc && !clr) begin
         win_q <= win_d;
         for (int r = 0; r < K-2; r++) lb_q[r][col_q] <= lb_q[r+1][col_q];
         lb_q[K-2][col_q] <= pix_data;
      end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rdy_q  <= 1'b0;
         vld_q  <= 1'b0;
         last_q <= 1'b0;
         data_q <= '0;
         col_q  <= '0;
         row_q  <= '0;
         cph_q  <= '0;
         rph_q  <= '0;
`ifdef GEN_WIN_COORD_EN
         wrow_q <= '0;
         wcol_q <= '0;
`endif
      end else begin
         rdy_q <= 1'b1;
         if (clr) begin
            vld_q  <= 1'b0;
            last_q <= 1'b0;
            col_q  <= '0;
            row_q  <= '0;
            cph_q  <= '0;
            rph_q  <= '0;
         end else begin
            if (vld_q && win_ready) vld_q <= 1'b0;
            if (acc) begin
               col_q <= col_d;
               row_q <= row_d;
               cph_q <= cph_d;
               rph_q <= rph_d;
               vld_q <= qual;
               if (qual) begin
                  data_q <= flat_d;
                  last_q <= col_end && row_end;
`ifdef GEN_WIN_COORD_EN
                  wrow_q <= row_q - RW'(K-1);
                  wcol_q <= col_q - CW'(K-1);
`endif
               end
            end
         end
      end
endmodule
